// File: rtl/sap1_datapath.sv
// sap1_datapath: executing half of a SAP-1 CPU. Takes the 12-bit control word from the
// sequencer and holds PC, MAR, a 16x8 RAM, IR, A, B and the adder/subtractor around one
// shared bus. A program-load port fills RAM while in reset or halted.
//
// Optional build macro: SAP1_FLAGS_EN adds zero/carry flag registers updated on
// ADDER_EN|A_LOAD. Without it zero_flag and carry_flag are tied to 0.
//
// Ports:
//   clk, rst      clock (rising edge), synchronous active-high reset
//   ctrl[11:0]    HLT, PC_INC, PC_EN, MEM_LOAD, MEM_EN, IR_LOAD, IR_EN, A_LOAD, A_EN,
//                 B_LOAD, ADDER_SUB, ADDER_EN (bit 11 down to bit 0)
//   prog_we/addr/data   RAM program write port (only honoured in reset or halted)
//   opcode        IR upper nibble to the sequencer
//   bus           current bus value (combinational)
//   a_out, pc_out A register and program counter
//   halted        HLT latched
//   bus_conflict  registered: more than one bus driver was enabled last cycle
//   zero_flag, carry_flag   adder flags (see macro above)
module sap1_datapath #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [11:0]       ctrl,
    input  logic              prog_we,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [DATA_W-1:0] prog_data,
    output logic [3:0]        opcode,
    output logic [DATA_W-1:0] bus,
    output logic [DATA_W-1:0] a_out,
    output logic [ADDR_W-1:0] pc_out,
    output logic              halted,
    output logic              bus_conflict,
    output logic              zero_flag,
    output logic              carry_flag
);

    localparam int unsigned Depth = 2 ** ADDR_W;
    localparam logic [DATA_W:0] AddOne = 1;
    localparam logic [ADDR_W-1:0] PcOne = 1;

    logic hlt, pc_inc, pc_en, mem_load, mem_en, ir_load, ir_en;
    logic a_load, a_en, b_load, adder_sub, adder_en;

    assign hlt       = ctrl[11];
    assign pc_inc    = ctrl[10];
    assign pc_en     = ctrl[9];
    assign mem_load  = ctrl[8];
    assign mem_en    = ctrl[7];
    assign ir_load   = ctrl[6];
    assign ir_en     = ctrl[5];
    assign a_load    = ctrl[4];
    assign a_en      = ctrl[3];
    assign b_load    = ctrl[2];
    assign adder_sub = ctrl[1];
    assign adder_en  = ctrl[0];

    logic [ADDR_W-1:0] pc, mar;
    logic [DATA_W-1:0] ir, a, b;
    logic [DATA_W-1:0] ram [Depth];

    logic [DATA_W:0]   adder_full;
    logic [DATA_W-1:0] sum;
    logic              carry;
    logic              conflict;

    // Subtract is a + ~b + 1, so carry = 1 means no borrow.
    always_comb begin
        adder_full = '0;
        if (adder_sub) begin
            adder_full = {1'b0, a} + {1'b0, ~b} + AddOne;
        end else begin
            adder_full = {1'b0, a} + {1'b0, b};
        end
    end

    assign sum   = adder_full[DATA_W-1:0];
    assign carry = adder_full[DATA_W];

    // Fixed priority ADDER > A > IR > MEM > PC; undriven bus reads 0.
    always_comb begin
        bus = '0;
        if (adder_en) begin
            bus = sum;
        end else if (a_en) begin
            bus = a;
        end else if (ir_en) begin
            bus = {{(DATA_W-ADDR_W){1'b0}}, ir[ADDR_W-1:0]};
        end else if (mem_en) begin
            bus = ram[mar];
        end else if (pc_en) begin
            bus = {{(DATA_W-ADDR_W){1'b0}}, pc};
        end
    end

    assign conflict = $countones({adder_en, a_en, ir_en, mem_en, pc_en}) > 1;

    always_ff @(posedge clk) begin
        if (rst) begin
            pc           <= '0;
            mar          <= '0;
            ir           <= '0;
            a            <= '0;
            b            <= '0;
            halted       <= 1'b0;
            bus_conflict <= 1'b0;
        end else begin
            // Conflict tracking runs even when halted.
            bus_conflict <= conflict;
            if (!halted) begin
                if (mem_load) mar <= bus[ADDR_W-1:0];
                if (ir_load)  ir  <= bus;
                if (a_load)   a   <= bus;
                if (b_load)   b   <= bus;
                if (pc_inc)   pc  <= pc + PcOne;
                if (hlt)      halted <= 1'b1;
            end
        end
    end

    // RAM is never cleared; it may only be written while the datapath is stopped.
    always_ff @(posedge clk) begin
        if (prog_we && (rst || halted)) begin
            ram[prog_addr] <= prog_data;
        end
    end

`ifdef SAP1_FLAGS_EN
    logic zero_q, carry_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            zero_q  <= 1'b0;
            carry_q <= 1'b0;
        end else if (!halted && a_load && adder_en) begin
            zero_q  <= (sum == '0);
            carry_q <= carry;
        end
    end

    assign zero_flag  = zero_q;
    assign carry_flag = carry_q;
`else
    logic unused_carry;
    assign unused_carry = carry;
    assign zero_flag    = 1'b0;
    assign carry_flag   = 1'b0;
`endif

    assign opcode = ir[DATA_W-1 -: 4];
    assign a_out  = a;
    assign pc_out = pc;

endmodule

// File: tb/tb_sap1_datapath.sv
// Directed bench for sap1_datapath: drives SAP-1 fetch/execute control sequences and
// checks A, PC, halt, bus, conflict and flag behaviour against hand-computed values.
module tb_sap1_datapath;

    localparam logic [11:0] CtlHlt      = 12'h800;
    localparam logic [11:0] CtlPcInc    = 12'h400;
    localparam logic [11:0] CtlPcEn     = 12'h200;
    localparam logic [11:0] CtlMemLoad  = 12'h100;
    localparam logic [11:0] CtlMemEn    = 12'h080;
    localparam logic [11:0] CtlIrLoad   = 12'h040;
    localparam logic [11:0] CtlIrEn     = 12'h020;
    localparam logic [11:0] CtlALoad    = 12'h010;
    localparam logic [11:0] CtlAEn      = 12'h008;
    localparam logic [11:0] CtlBLoad    = 12'h004;
    localparam logic [11:0] CtlAdderSub = 12'h002;
    localparam logic [11:0] CtlAdderEn  = 12'h001;

`ifdef SAP1_FLAGS_EN
    localparam bit FlagsOn = 1'b1;
`else
    localparam bit FlagsOn = 1'b0;
`endif

    localparam int InsLda = 0;
    localparam int InsAdd = 1;
    localparam int InsSub = 2;
    localparam int InsHlt = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [11:0] ctrl = '0;
    logic        prog_we = 1'b0;
    logic [3:0]  prog_addr = '0;
    logic [7:0]  prog_data = '0;
    logic [3:0]  opcode;
    logic [7:0]  bus;
    logic [7:0]  a_out;
    logic [3:0]  pc_out;
    logic        halted;
    logic        bus_conflict;
    logic        zero_flag;
    logic        carry_flag;

    int checks = 0;
    int failures = 0;

    sap1_datapath #(
        .DATA_W(8),
        .ADDR_W(4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .ctrl        (ctrl),
        .prog_we     (prog_we),
        .prog_addr   (prog_addr),
        .prog_data   (prog_data),
        .opcode      (opcode),
        .bus         (bus),
        .a_out       (a_out),
        .pc_out      (pc_out),
        .halted      (halted),
        .bus_conflict(bus_conflict),
        .zero_flag   (zero_flag),
        .carry_flag  (carry_flag)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step(input logic [11:0] c);
        ctrl = c;
        @(posedge clk);
        #1;
    endtask

    task automatic pwrite(input logic [3:0] addr, input logic [7:0] data);
        prog_we   = 1'b1;
        prog_addr = addr;
        prog_data = data;
        @(posedge clk);
        #1;
        prog_we = 1'b0;
    endtask

    task automatic enter_reset();
        rst = 1'b1;
        step('0);
    endtask

    task automatic leave_reset();
        rst = 1'b0;
        ctrl = '0;
    endtask

    // Six-state SAP-1 instruction: three fetch states then three execute states.
    task automatic run_instr(input int kind);
        step(CtlPcEn | CtlMemLoad);
        step(CtlPcInc);
        step(CtlMemEn | CtlIrLoad);
        case (kind)
            InsLda: begin
                step(CtlIrEn | CtlMemLoad);
                step(CtlMemEn | CtlALoad);
                step('0);
            end
            InsAdd: begin
                step(CtlIrEn | CtlMemLoad);
                step(CtlMemEn | CtlBLoad);
                step(CtlAdderEn | CtlALoad);
            end
            InsSub: begin
                step(CtlIrEn | CtlMemLoad);
                step(CtlMemEn | CtlBLoad);
                step(CtlAdderSub | CtlAdderEn | CtlALoad);
            end
            default: begin
                step(CtlHlt);
                step('0);
                step('0);
            end
        endcase
        ctrl = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        // Reset state
        enter_reset();
        step('0);
        check("rst_pc", pc_out, 0);
        check("rst_a", a_out, 0);
        check("rst_halted", halted, 0);
        check("rst_conflict", bus_conflict, 0);
        check("rst_opcode", opcode, 0);
        check("rst_bus", bus, 0);
        check("rst_zero", zero_flag, 0);
        check("rst_carry", carry_flag, 0);

        // Program and run: LDA 9, ADD 10, SUB 11, HLT
        pwrite(4'd0, 8'h09);
        pwrite(4'd1, 8'h1A);
        pwrite(4'd2, 8'h2B);
        pwrite(4'd3, 8'hF0);
        pwrite(4'd9, 8'h10);
        pwrite(4'd10, 8'h14);
        pwrite(4'd11, 8'h04);
        leave_reset();
        run_instr(InsLda);
        check("prog_lda_a", a_out, 8'h10);
        run_instr(InsAdd);
        check("prog_add_opcode", opcode, 4'h1);
        check("prog_add_a", a_out, 8'h24);
        run_instr(InsSub);
        check("prog_sub_a", a_out, 8'h20);
        check("prog_sub_carry", carry_flag, FlagsOn ? 1 : 0);
        check("prog_sub_zero", zero_flag, 0);
        run_instr(InsHlt);
        check("prog_halted", halted, 1);
        check("prog_pc", pc_out, 4'd4);
        check("prog_hlt_opcode", opcode, 4'hF);

        // Halted: ctrl ignored, program port live
        step(CtlPcInc | CtlALoad | CtlMemEn);
        step(CtlPcInc | CtlALoad | CtlAdderEn);
        check("halt_pc_hold", pc_out, 4'd4);
        check("halt_a_hold", a_out, 8'h20);
        check("halt_still", halted, 1);
        pwrite(4'd12, 8'h77);

        // Write while running must be ignored; halted write to ram[12] must survive reset
        enter_reset();
        pwrite(4'd0, 8'h0C);
        pwrite(4'd1, 8'h0D);
        pwrite(4'd13, 8'h11);
        leave_reset();
        check("reset_clears_halt", halted, 0);
        pwrite(4'd13, 8'h66);
        run_instr(InsLda);
        check("halted_write_lands", a_out, 8'h77);
        run_instr(InsLda);
        check("running_write_ignored", a_out, 8'h11);

        // Wrap/carry then subtract with borrow; LDA must not touch the flags
        enter_reset();
        pwrite(4'd0, 8'h04);
        pwrite(4'd1, 8'h15);
        pwrite(4'd2, 8'h06);
        pwrite(4'd3, 8'h27);
        pwrite(4'd4, 8'hFF);
        pwrite(4'd5, 8'h01);
        pwrite(4'd6, 8'h03);
        pwrite(4'd7, 8'h05);
        leave_reset();
        run_instr(InsLda);
        run_instr(InsAdd);
        check("wrap_a", a_out, 8'h00);
        check("wrap_zero", zero_flag, FlagsOn ? 1 : 0);
        check("wrap_carry", carry_flag, FlagsOn ? 1 : 0);
        run_instr(InsLda);
        check("lda_a", a_out, 8'h03);
        check("lda_zero_hold", zero_flag, FlagsOn ? 1 : 0);
        check("lda_carry_hold", carry_flag, FlagsOn ? 1 : 0);
        run_instr(InsSub);
        check("borrow_a", a_out, 8'hFE);
        check("borrow_carry", carry_flag, 0);
        check("borrow_zero", zero_flag, 0);

        // Bus conflict with a = 0x5A, pc = 3
        enter_reset();
        pwrite(4'd0, 8'h04);
        pwrite(4'd4, 8'h5A);
        leave_reset();
        run_instr(InsLda);
        step(CtlPcInc);
        step(CtlPcInc);
        check("conf_pc", pc_out, 4'd3);
        ctrl = CtlPcEn | CtlAEn | CtlBLoad;
        #1;
        check("conf_bus_prio", bus, 8'h5A);
        check("conf_pre", bus_conflict, 0);
        @(posedge clk);
        #1;
        check("conf_flag", bus_conflict, 1);
        check("conf_pc_hold", pc_out, 4'd3);
        ctrl = CtlAdderEn;
        #1;
        check("conf_b_loaded", bus, 8'hB4);
        @(posedge clk);
        #1;
        check("conf_one_cycle", bus_conflict, 0);
        ctrl = CtlPcEn | CtlPcInc;
        #1;
        check("pcen_inc_bus", bus, 8'h03);
        @(posedge clk);
        #1;
        check("pcen_inc_pc", pc_out, 4'd4);
        ctrl = CtlIrEn | CtlMemEn;
        #1;
        check("ir_over_mem", bus, 8'h04);
        ctrl = '0;
        #1;
        check("bus_idle", bus, 8'h00);

        // PC wrap and reset priority over HLT/PC_INC
        enter_reset();
        pwrite(4'd0, 8'h0E);
        pwrite(4'd14, 8'h3C);
        leave_reset();
        run_instr(InsLda);
        check("rp_lda_a", a_out, 8'h3C);
        for (int i = 0; i < 14; i++) step(CtlPcInc);
        check("rp_pc15", pc_out, 4'd15);
        step(CtlPcInc);
        check("pc_wrap", pc_out, 4'd0);
        for (int i = 0; i < 15; i++) step(CtlPcInc);
        check("rp_pc15_again", pc_out, 4'd15);
        rst = 1'b1;
        step(CtlHlt | CtlPcInc);
        check("rp_pc", pc_out, 4'd0);
        check("rp_halted", halted, 0);
        check("rp_a", a_out, 8'h00);
        leave_reset();
        run_instr(InsLda);
        check("rp_ram_kept", a_out, 8'h3C);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
